// File: rtl/mem_if_pkg.sv
// Shared types, marker constants and packet pack/unpack helpers for mem_if.
// Latency: none; these are pure combinational functions.
// Backpressure: not applicable. The helpers work on words up to MAX_WORD_WIDTH bits.
package mem_if_pkg;

    typedef enum logic [1:0] {
        S_RD_ADDR = 2'd0,
        S_WR_ADDR = 2'd1,
        S_DATA    = 2'd2
    } mem_if_state_t;

    localparam logic [1:0] MARK_HI = 2'b01;
    localparam logic [1:0] MARK_LO = 2'b10;

    // Callers zero-extend into these containers and pass the real word width.
    localparam int MAX_WORD_WIDTH   = 32;
    localparam int MAX_PACKET_WIDTH = MAX_WORD_WIDTH + 4;

    typedef logic [MAX_WORD_WIDTH-1:0]   max_word_t;
    typedef logic [MAX_PACKET_WIDTH-1:0] max_packet_t;

    // Mask covering one nibble of a word_width-bit word.
    function automatic max_word_t nibble_mask(input int word_width);
        return (max_word_t'(1) << (word_width / 2)) - max_word_t'(1);
    endfunction

    // Packet layout: {MARK_HI, word[hi half], MARK_LO, word[lo half]}.
    function automatic max_packet_t pack_word(input max_word_t word, input int word_width);
        max_word_t mask;
        int        half;
        half = word_width / 2;
        mask = nibble_mask(word_width);
        return max_packet_t'(word & mask)
             | (max_packet_t'(MARK_LO) << half)
             | (max_packet_t'((word >> half) & mask) << (half + 2))
             | (max_packet_t'(MARK_HI) << (word_width + 2));
    endfunction

    // Drops both marker pairs and joins the two nibbles back into a word.
    function automatic max_word_t unpack_word(input max_packet_t pkt, input int word_width);
        max_word_t mask;
        int        half;
        half = word_width / 2;
        mask = nibble_mask(word_width);
        return (max_word_t'(pkt) & mask)
             | ((max_word_t'(pkt >> (half + 2)) & mask) << half);
    endfunction

    // True when both marker pairs sit where the layout expects them.
    function automatic logic is_valid(input max_packet_t pkt, input int word_width);
        return (2'(pkt >> (word_width + 2)) == MARK_HI)
            && (2'(pkt >> (word_width / 2)) == MARK_LO);
    endfunction

endpackage

// File: rtl/mem_if_if.sv
// Bundle between the packet engine, the serdes and the RAM.
// Latency: none; this is wiring only.
// Backpressure: none. dataReady is a strobe and the RAM always accepts.
interface mem_if_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    localparam int PACKET_WIDTH = WORD_WIDTH + 4;

    logic                    dataReady;
    logic [PACKET_WIDTH-1:0] inPacket;
    logic [PACKET_WIDTH-1:0] outPacket;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [WORD_WIDTH-1:0]   rd_data;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [WORD_WIDTH-1:0]   wr_data;
    logic                    wr_enable;
    logic                    inPacketIsValid;

    // The environment side: the serdes drives packets in and the RAM returns read data.
    modport master (
        output dataReady, inPacket, rd_data,
        input  outPacket, rd_addr, wr_addr, wr_data, wr_enable, inPacketIsValid
    );

    // The engine side.
    modport slave (
        input  dataReady, inPacket, rd_data,
        output outPacket, rd_addr, wr_addr, wr_data, wr_enable, inPacketIsValid
    );
endinterface

// File: rtl/mem_if_codec.sv
// Unpacks the incoming packet into a word plus a marker check, and packs RAM read data.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module mem_if_codec
    import mem_if_pkg::*;
#(
    parameter int  WORD_WIDTH   = 8,
    localparam int PACKET_WIDTH = WORD_WIDTH + 4
) (
    input  logic [PACKET_WIDTH-1:0] in_packet_i,
    input  logic [WORD_WIDTH-1:0]   rd_data_i,
    output logic [WORD_WIDTH-1:0]   word_o,
    output logic                    in_valid_o,
    output logic [PACKET_WIDTH-1:0] rd_packet_o
);

    assign word_o      = WORD_WIDTH'(unpack_word(max_packet_t'(in_packet_i), WORD_WIDTH));
    assign in_valid_o  = is_valid(max_packet_t'(in_packet_i), WORD_WIDTH);
    assign rd_packet_o = PACKET_WIDTH'(pack_word(max_word_t'(rd_data_i), WORD_WIDTH));

endmodule

// File: rtl/mem_if.sv
// Packet-level RAM access engine: 1st packet = read address, 2nd = write address, rest = data.
// Latency: the write strobe comes 1 clk after dataReady; outPacket refreshes 3 clks after it.
// Backpressure: none; the serdes must space loads >= 4 clks. MEM_IF_STRICT_EN: invalid packet restarts protocol.
module mem_if
    import mem_if_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    mem_if_if.slave  bus
);

    localparam int PACKET_WIDTH = WORD_WIDTH + 4;
    localparam logic [PACKET_WIDTH-1:0] OUT_RST =
        PACKET_WIDTH'(pack_word(max_word_t'(0), WORD_WIDTH));

    logic [WORD_WIDTH-1:0]   word;
    logic                    in_valid;
    logic [PACKET_WIDTH-1:0] rd_packet;
    logic                    accept;
    logic                    rd_upd;

    mem_if_state_t           state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q,   wr_en_d;
    // Two-stage tracker following each rd_addr change through the RAM's registered read.
    logic                    rd_vld1_q, rd_vld1_d;
    logic                    rd_vld2_q, rd_vld2_d;
    logic [PACKET_WIDTH-1:0] out_pkt_q, out_pkt_d;

    mem_if_codec #(.WORD_WIDTH(WORD_WIDTH)) u_codec (
        .in_packet_i (bus.inPacket),
        .rd_data_i   (bus.rd_data),
        .word_o      (word),
        .in_valid_o  (in_valid),
        .rd_packet_o (rd_packet)
    );

    assign accept = bus.dataReady && in_valid;

    // Protocol FSM and pointer/write next-state; a write lands first, then its address advances.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_upd    = 1'b0;

        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end

        if (accept) begin
            case (state_q)
                S_RD_ADDR: begin
                    rd_addr_d = word[ADDR_WIDTH-1:0];
                    rd_upd    = 1'b1;
                    state_d   = S_WR_ADDR;
                end
                S_WR_ADDR: begin
                    wr_addr_d = word[ADDR_WIDTH-1:0];
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    wr_data_d = word;
                    wr_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_upd    = 1'b1;
                end
                default: begin
                    state_d = S_RD_ADDR;
                end
            endcase
        end
`ifdef MEM_IF_STRICT_EN
        else if (bus.dataReady) begin
            // A corrupt packet means the frame is out of step, so restart the protocol.
            state_d = S_RD_ADDR;
        end
`endif
    end

    // Read pipeline: RAM data for a new rd_addr is ready two clks after the update.
    always_comb begin
        rd_vld1_d = rd_upd;
        rd_vld2_d = rd_vld1_q;
        out_pkt_d = rd_vld2_q ? rd_packet : out_pkt_q;
    end

    // State registers; reset (driven from slave-select) restarts the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RD_ADDR;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_vld1_q <= 1'b0;
            rd_vld2_q <= 1'b0;
            out_pkt_q <= OUT_RST;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_vld1_q <= rd_vld1_d;
            rd_vld2_q <= rd_vld2_d;
            out_pkt_q <= out_pkt_d;
        end
    end

    assign bus.outPacket       = out_pkt_q;
    assign bus.rd_addr         = rd_addr_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.wr_enable       = wr_en_q;
    assign bus.inPacketIsValid = in_valid;

endmodule

// File: tb/tb_mem_if.sv
// Bench for mem_if at 8-bit words / 4-entry RAM with a scoreboard of expected writes.
// Latency: expects the write strobe 1 clk after dataReady and outPacket 3 clks after it.
// Backpressure: the stimulus leaves >= 4 clks between loads except in the back-to-back case.
module tb_mem_if;

    logic clk = 1'b0;
    logic reset;
    logic ram_clr;
    logic pl_en;
    logic [1:0] pl_addr;
    logic [7:0] pl_dat;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_if_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) bus ();

    mem_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one clk of read latency (read-before-write).
    logic [7:0] ram [4];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 4; i++) ram[i] <= 8'h00;
        end else begin
            if (bus.wr_enable === 1'b1) ram[bus.wr_addr] <= bus.wr_data;
            if (pl_en) ram[pl_addr] <= pl_dat;
        end
        bus.rd_data <= ram[bus.rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pk(input logic [7:0] w);
        return {2'b01, w[7:4], 2'b10, w[3:0]};
    endfunction

    // Scoreboard of expected writes, each stamped with the cycle it must appear in.
    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t wq[$];
    wr_t wexp;

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.wr_enable === 1'b1) begin
            check("wr_pending", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                wexp = wq.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(wexp.addr));
                check("wr_data", 32'(bus.wr_data), 32'(wexp.data));
                check("wr_cycle", 32'(cyc), 32'(wexp.cyc));
            end
        end
    end

    // Reference protocol model.
    int          m_state;
    logic [1:0]  m_rd, m_wr;
    logic [7:0]  m_mem [4];
    logic [11:0] m_out;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rd    = 2'd0;
        m_wr    = 2'd0;
        m_out   = 12'h420;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_out"},  32'(bus.outPacket), 32'(m_out));
        check({tag, "_rd"},   32'(bus.rd_addr),   32'(m_rd));
        check({tag, "_wr"},   32'(bus.wr_addr),   32'(m_wr));
        check({tag, "_wren"}, 32'(bus.wr_enable), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        model_reset();
        check_regs("reset");
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        idle(1);
        pl_en = 1'b0;
        m_mem[a] = d;
    endtask

    // Drives one packet for one clk; called and returns 1ns after a rising edge.
    task automatic send(input logic [11:0] pkt);
        logic       ok;
        logic [7:0] w;
        wr_t        e;
        ok = (pkt[11:10] == 2'b01) && (pkt[5:4] == 2'b10);
        w  = {pkt[9:6], pkt[3:0]};
        bus.dataReady = 1'b1;
        bus.inPacket  = pkt;
        #1;
        check("pkt_valid", 32'(bus.inPacketIsValid), 32'(ok));
        if (ok) begin
            case (m_state)
                0: begin
                    m_rd    = w[1:0];
                    m_out   = pk(m_mem[m_rd]);
                    m_state = 1;
                end
                1: begin
                    m_wr    = w[1:0];
                    m_state = 2;
                end
                default: begin
                    e.addr = m_wr; e.data = w; e.cyc = cyc + 1;
                    wq.push_back(e);
                    m_rd  = m_rd + 2'd1;
                    m_out = pk(m_mem[m_rd]);
                    m_mem[m_wr] = w;
                    m_wr  = m_wr + 2'd1;
                end
            endcase
        end
`ifdef MEM_IF_STRICT_EN
        else begin
            m_state = 0;
        end
`endif
        @(posedge clk);
        #1;
        bus.dataReady = 1'b0;
        bus.inPacket  = 12'h000;
    endtask

    task automatic sendw(input logic [11:0] pkt);
        send(pkt);
        idle(3);
        check_regs("pkt");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ram_clr = 1'b1; pl_en = 1'b0; pl_addr = 2'd0; pl_dat = 8'h00;
        bus.dataReady = 1'b0; bus.inPacket = 12'h000;
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        model_reset();

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; ram_clr = 1'b0;
        check("rst_out", 32'(bus.outPacket), 32'h420);
        check_regs("init");

        // 2. address packets then five data words with wrap-around
        sendw(pk(8'h00));
        sendw(pk(8'h01));
        for (int i = 1; i <= 5; i++) sendw(pk(8'(i)));
        check("ram0", 32'(ram[0]), 32'h04);
        check("ram1", 32'(ram[1]), 32'h05);
        check("ram2", 32'(ram[2]), 32'h02);
        check("ram3", 32'(ram[3]), 32'h03);

        // 3. readback stream following rd_addr
        do_reset();
        preload(2'd2, 8'hA5);
        sendw(pk(8'h02));
        check("rd_a5", 32'(bus.outPacket), 32'h6A5);
        sendw(pk(8'h01));
        sendw(pk(8'h11));
        check("rd_m3", 32'(bus.outPacket), 32'h423);
        sendw(pk(8'h22));
        check("rd_m0", 32'(bus.outPacket), 32'h424);

        // 4. invalid packets in every state
        do_reset();
        sendw(12'h000);
        sendw(pk(8'h01));
        sendw(12'h000);
        sendw(pk(8'h02));
        sendw(12'h000);
        sendw(pk(8'h5A));
        sendw(pk(8'h6B));
        sendw(12'hFFF);
        sendw(pk(8'h7C));

        // 5. reset mid-stream restarts the protocol
        do_reset();
        sendw(pk(8'h00));
        sendw(pk(8'h00));
        sendw(pk(8'h09));
        sendw(pk(8'h08));
        preload(2'd3, 8'h3C);
        do_reset();
        sendw(pk(8'h03));
        check("rst_rd3", 32'(bus.outPacket), 32'h4EC);
        sendw(pk(8'h02));
        sendw(pk(8'h77));
        check("ram2_77", 32'(ram[2]), 32'h77);

        // 6. back-to-back data packets
        send(pk(8'hC1));
        send(pk(8'hC2));
        idle(3);
        check_regs("b2b");
        check("b2b_out", 32'(bus.outPacket), 32'h5E7);
        check("b2b_ram3", 32'(ram[3]), 32'hC1);
        check("b2b_ram0", 32'(ram[0]), 32'hC2);

        idle(2);
        check("wr_left", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
